// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling at CLKS_PER_BIT clocks per bit.
// Good frames update data_out with a data_valid pulse; a low stop bit pulses frame_err and waits for idle.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t           state_q;
   logic             rx_meta_q;
   logic             rx_s_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic [7:0]       shift_d;
   logic [7:0]       data_out_q;
   logic             data_valid_q;
   logic             frame_err_q;

   assign cnt_d   = cnt_q + CNT_W'(1);
   assign shift_d = {rx_s_q, shift_q[7:1]};

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q      <= IDLE;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         cnt_q        <= '0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'h00;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!rx_s_q) state_q <= START;
            end
            START: begin
               // A line that is high again at mid start bit was a glitch.
               if (cnt_q == HALF_LAST) begin
                  cnt_q     <= '0;
                  bit_idx_q <= 3'd0;
                  state_q   <= rx_s_q ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DATA: begin
               if (cnt_q == BIT_LAST) begin
                  shift_q   <= shift_d;
                  cnt_q     <= '0;
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_q <= STOP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     data_out_q   <= shift_q;
                     data_valid_q <= 1'b1;
                     state_q      <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            WAIT_HIGH: begin
               // A held-low line (break) must go idle before a new start is accepted.
               if (rx_s_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are even integers >= 4.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear, input, 1, the reset; it is synchronous and active-high.
REQ-004 The block SHALL have port rx, input, 1, the asynchronous serial line; it idles high and frames are 8N1, LSB first.
REQ-005 The block SHALL have port data_out, output, 8, the last correctly framed byte; it is held until the next good frame.
REQ-006 The block SHALL have port data_valid, output, 1, a one-cycle pulse when data_out is updated.
REQ-007 The block SHALL have port frame_err, output, 1, a one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-009 The block SHALL pass rx through a 2-flop synchronizer; the second flop output (rx_s) is the only internal view of the line.
REQ-010 The block SHALL implement five states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011 In IDLE, rx_s=0 SHALL cause a move to START with the cycle counter cleared to 0.
REQ-012 In START, at counter = CLKS_PER_BIT/2-1 the block SHALL sample rx_s: 0 -> DATA (counter=0, bit_idx=0); 1 -> IDLE as a glitch, with no output pulse.
REQ-013 In DATA, at counter = CLKS_PER_BIT-1 the block SHALL sample rx_s into shift[7] with shift right, clear counter and increment bit_idx; after the sample with bit_idx=7 it SHALL move to STOP.
REQ-014 In STOP, at counter = CLKS_PER_BIT-1 the block SHALL sample rx_s: 1 -> load data_out from shift, pulse data_valid, go to IDLE; 0 -> pulse frame_err, leave data_out unchanged, go to WAIT_HIGH.
REQ-015 WAIT_HIGH SHALL remain until rx_s=1, then go to IDLE, so that a break condition never retriggers START.
REQ-016 data_valid and frame_err SHALL be registered, assert in the cycle after the stop-bit sample, and never assert together.
REQ-017 Sampling points SHALL be mid-bit: the start sample is CLKS_PER_BIT/2 cycles after the falling edge is seen on rx_s, and each later sample is exactly CLKS_PER_BIT cycles after the previous one.
REQ-018 A falling edge arriving in the cycle of a data_valid pulse SHALL be detected on the next cycle from IDLE (back-to-back frames, zero idle bits, supported).
REQ-019 The counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap inside a bit period.
REQ-020 rx activity while in DATA SHALL be ignored except at sample points; there SHALL be no resync to edges mid-frame.

Reset
REQ-021 While clear=1 at a rising clk edge, the block SHALL set: state=IDLE, counter=0, bit_idx=0, shift=0x00, data_out=0x00, data_valid=0, frame_err=0, busy=0, and both synchronizer flops=1.
REQ-022 clear asserted mid-frame SHALL abandon the frame with no valid or error pulse; reception SHALL resume on the first falling edge after clear deasserts.

Verification
REQ-023 The bench SHALL cover this case: frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1 -> data_out=0xA5, data_valid high exactly 1 cycle, frame_err=0.
REQ-024 The bench SHALL cover this case: rx low for 3 cycles then high (CLKS_PER_BIT=16) -> return to IDLE, no data_valid, no frame_err, data_out unchanged.
REQ-025 The bench SHALL cover this case: frame 0x3C with stop=0, held low for 2 bit times -> frame_err 1-cycle pulse, data_out keeps the prior value, busy high until rx returns to 1.
REQ-026 The bench SHALL cover this case: back-to-back 0x00 then 0xFF with no idle bits -> two data_valid pulses CLKS_PER_BIT*10 cycles apart, data_out 0x00 then 0xFF.
REQ-027 The bench SHALL cover this case: clear pulsed during bit 4 of a frame -> all outputs 0 the next cycle, no pulse; a following 0x5A frame is received correctly.
REQ-028 The bench SHALL cover this case: CLKS_PER_BIT=4 with frame 0x81 -> data_out=0x81, which checks the minimum-divisor boundary.
